// File: rtl/fifo_umbrales_if.sv
// rtl/fifo_umbrales_if.sv - handshake/data bundle between a FIFO bank slot and its driver
// Purpose: groups the threshold, push/pop, data and status signals of one fifo_umbrales.
// Ports (signals):
//   init, umbral_alto[7:0], umbral_bajo[7:0]  threshold load enable and values
//   push, data_in[DATA_WIDTH-1:0]             write request and data
//   pop                                       read request
//   data_out, valid_out                       registered read data and its qualifier
//   fifo_full, fifo_empty, almost_full,
//   almost_empty, fifo_error, count           status
// Modports: master drives requests, slave (the FIFO) drives status.
interface fifo_umbrales_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  init;
  logic [7:0]            umbral_alto;
  logic [7:0]            umbral_bajo;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output init, umbral_alto, umbral_bajo, push, data_in, pop,
    input  data_out, valid_out, fifo_full, fifo_empty, almost_full,
           almost_empty, fifo_error, count
  );

  modport slave (
    input  init, umbral_alto, umbral_bajo, push, data_in, pop,
    output data_out, valid_out, fifo_full, fifo_empty, almost_full,
           almost_empty, fifo_error, count
  );
endinterface

// File: rtl/fifo_umbrales.sv
// rtl/fifo_umbrales.sv - synchronous FIFO with programmable almost-full/empty thresholds
// Purpose: one slot of the flow-control buffer bank; sticky error on overflow/underflow.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    fifo_umbrales_if.slave (requests in, data/status out)
module fifo_umbrales #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input logic           clk,
  input logic           reset,
  fifo_umbrales_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [7:0]            ALTO_RST  = 8'(DEPTH - 1);
  localparam logic [7:0]            BAJO_RST  = 8'd1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic [7:0]            alto_q, alto_d;
  logic [7:0]            bajo_q, bajo_d;

  logic full, empty, rd_ok, wr_ok, overflow, underflow;
  logic [7:0] count_ext;

  assign full      = (count_q == CNT_DEPTH);
  assign empty     = (count_q == '0);
  assign count_ext = 8'(count_q);

  // A pop on a full FIFO frees a slot in the same edge, so push is still taken.
  assign rd_ok     = bus.pop & ~empty;
  assign wr_ok     = bus.push & (~full | rd_ok);
  assign overflow  = bus.push & full & ~rd_ok;
  assign underflow = bus.pop & empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = rd_ok;
    error_d    = error_q | overflow | underflow;
    alto_d     = alto_q;
    bajo_d     = bajo_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem[rd_ptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (bus.init) begin
      alto_d = bus.umbral_alto;
      bajo_d = bus.umbral_bajo;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      alto_q     <= ALTO_RST;
      bajo_q     <= BAJO_RST;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
    end
  end

  // Storage is not cleared by reset; only the write itself is blocked during reset.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count_ext >= alto_q);
  assign bus.almost_empty = (count_ext <= bajo_q);
  assign bus.fifo_error   = error_q;
  assign bus.count        = count_q;
endmodule

// File: tb/tb_fifo_umbrales.sv
// tb/tb_fifo_umbrales.sv - directed self-checking bench for fifo_umbrales
// Purpose: drives the FIFO through its interface and checks flags, data order and errors.
// Ports: none (top-level bench).
module tb_fifo_umbrales;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fifo_umbrales_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) bus_if ();

  fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_io(input logic p, input logic [5:0] d, input logic q);
    bus_if.push    = p;
    bus_if.data_in = d;
    bus_if.pop     = q;
  endtask

  initial begin
    reset              = 1'b0;
    bus_if.init        = 1'b0;
    bus_if.umbral_alto = 8'd0;
    bus_if.umbral_bajo = 8'd0;
    set_io(1'b0, 6'h0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Reset state
    chk("rst_count", 32'(bus_if.count), 0);
    chk("rst_empty", 32'(bus_if.fifo_empty), 1);
    chk("rst_aempty", 32'(bus_if.almost_empty), 1);
    chk("rst_full", 32'(bus_if.fifo_full), 0);
    chk("rst_afull", 32'(bus_if.almost_full), 0);
    chk("rst_error", 32'(bus_if.fifo_error), 0);
    chk("rst_valid", 32'(bus_if.valid_out), 0);

    // Thresholds 6/2, then push 1..6
    bus_if.init        = 1'b1;
    bus_if.umbral_alto = 8'd6;
    bus_if.umbral_bajo = 8'd2;
    tick();
    bus_if.init = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      set_io(1'b1, 6'(i), 1'b0);
      tick();
      chk("fill_count", 32'(bus_if.count), 32'(i));
      chk("fill_aempty", 32'(bus_if.almost_empty), 32'(i <= 2));
      chk("fill_afull", 32'(bus_if.almost_full), 32'(i >= 6));
    end

    // Pop 6: 1-cycle latency, order 1..6
    for (int i = 1; i <= 6; i++) begin
      set_io(1'b0, 6'h0, 1'b1);
      tick();
      chk("drain_data", 32'(bus_if.data_out), 32'(i));
      chk("drain_valid", 32'(bus_if.valid_out), 1);
      chk("drain_count", 32'(bus_if.count), 32'(6 - i));
      chk("drain_aempty", 32'(bus_if.almost_empty), 32'((6 - i) <= 2));
    end
    set_io(1'b0, 6'h0, 1'b0);
    tick();
    chk("idle_valid", 32'(bus_if.valid_out), 0);
    chk("idle_hold", 32'(bus_if.data_out), 32'h06);

    // Fill to 8 (pointers start at 6, so storage wraps)
    for (int i = 0; i < 8; i++) begin
      set_io(1'b1, 6'(8'h10 + i), 1'b0);
      tick();
    end
    chk("full_count", 32'(bus_if.count), 8);
    chk("full_flag", 32'(bus_if.fifo_full), 1);

    // Push+pop on full for 4 cycles
    for (int i = 0; i < 4; i++) begin
      set_io(1'b1, 6'(8'h18 + i), 1'b1);
      tick();
      chk("pp_data", 32'(bus_if.data_out), 32'(8'h10 + i));
      chk("pp_count", 32'(bus_if.count), 8);
      chk("pp_full", 32'(bus_if.fifo_full), 1);
      chk("pp_error", 32'(bus_if.fifo_error), 0);
    end

    // Overflow: rejected word 0x3F never appears
    set_io(1'b1, 6'h3F, 1'b0);
    tick();
    chk("ovf_error", 32'(bus_if.fifo_error), 1);
    chk("ovf_count", 32'(bus_if.count), 8);
    for (int i = 0; i < 8; i++) begin
      set_io(1'b0, 6'h0, 1'b1);
      tick();
      chk("ovf_drain", 32'(bus_if.data_out), 32'(8'h14 + i));
    end
    chk("ovf_empty", 32'(bus_if.fifo_empty), 1);

    // Push+pop on empty: write taken, read is underflow
    set_io(1'b1, 6'h2A, 1'b1);
    tick();
    chk("udf_count", 32'(bus_if.count), 1);
    chk("udf_error", 32'(bus_if.fifo_error), 1);
    chk("udf_valid", 32'(bus_if.valid_out), 0);
    set_io(1'b0, 6'h0, 1'b1);
    tick();
    chk("udf_data", 32'(bus_if.data_out), 32'h2A);
    chk("udf_valid2", 32'(bus_if.valid_out), 1);

    // Load 5 words then reset mid-operation with push/pop/init asserted
    for (int i = 0; i < 5; i++) begin
      set_io(1'b1, 6'(i), 1'b0);
      tick();
    end
    chk("pre_rst_count", 32'(bus_if.count), 5);
    reset              = 1'b0;
    bus_if.init        = 1'b1;
    bus_if.umbral_alto = 8'd3;
    bus_if.umbral_bajo = 8'd3;
    set_io(1'b1, 6'h11, 1'b1);
    tick();
    reset       = 1'b1;
    bus_if.init = 1'b0;
    set_io(1'b0, 6'h0, 1'b0);
    chk("mid_rst_count", 32'(bus_if.count), 0);
    chk("mid_rst_error", 32'(bus_if.fifo_error), 0);
    chk("mid_rst_valid", 32'(bus_if.valid_out), 0);
    chk("mid_rst_aempty", 32'(bus_if.almost_empty), 1);

    // Default thresholds 7/1 after reset
    for (int i = 1; i <= 7; i++) begin
      set_io(1'b1, 6'(i), 1'b0);
      tick();
      chk("dflt_aempty", 32'(bus_if.almost_empty), 32'(i <= 1));
      chk("dflt_afull", 32'(bus_if.almost_full), 32'(i >= 7));
    end

    // Thresholds above DEPTH: alto 9 never asserts, bajo 8 always asserts
    set_io(1'b0, 6'h0, 1'b0);
    bus_if.init        = 1'b1;
    bus_if.umbral_alto = 8'd9;
    bus_if.umbral_bajo = 8'd8;
    tick();
    bus_if.init = 1'b0;
    set_io(1'b1, 6'h08, 1'b0);
    tick();
    set_io(1'b0, 6'h0, 1'b0);
    chk("big_full", 32'(bus_if.fifo_full), 1);
    chk("big_afull", 32'(bus_if.almost_full), 0);
    chk("big_aempty", 32'(bus_if.almost_empty), 1);
    chk("big_error", 32'(bus_if.fifo_error), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
